// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus-cycle initiator: state encoding,
// byte-enable bit positions and the read value returned on a timed-out cycle.
package m68k_bus_pkg;

  // One state per 68k half-state, plus the two halves of a wait pair
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_S0   = 4'd1,
    ST_S1   = 4'd2,
    ST_S2   = 4'd3,
    ST_S3   = 4'd4,
    ST_S4   = 4'd5,
    ST_S5   = 4'd6,
    ST_S6   = 4'd7,
    ST_S7   = 4'd8,
    ST_W1   = 4'd9,
    ST_W2   = 4'd10
  } busState_e;

  // Byte-enable vector is {upper, lower}
  localparam int BE_UPPER = 1;
  localparam int BE_LOWER = 0;

  // Width of the wait-pair counter
  localparam int WAIT_CNT_W = 5;

  // Data returned to the requester when a read is forcibly terminated
  localparam logic [15:0] RDATA_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/m68k_wait_timer.sv
// Wait-pair counter for the bus master. Cleared in S0, advanced once per
// inserted wait pair, and flags expiry once TIMEOUT_PAIRS pairs have elapsed.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module m68k_wait_timer
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_PAIRS = 16
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic pairStart,
  output logic expired
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = TIMEOUT_PAIRS[WAIT_CNT_W-1:0];
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  logic [WAIT_CNT_W-1:0] pairCount;

  // Count wait pairs; saturate rather than wrap so expiry cannot be missed
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pairCount <= '0;
    end else if (clear) begin
      pairCount <= '0;
    end else if (pairStart && (pairCount != CNT_MAX)) begin
      pairCount <= pairCount + 1'b1;
    end
  end

  assign expired = (pairCount >= LIMIT);

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 bus-cycle initiator: turns a REQ/ACK word request into a full
// S0..S7 nAS/nDS/nDTACK cycle, one half-state per CLK_24M cycle, with
// wait pairs inserted while nDTACK is high at the sample points.
// Optional feature macro: BUS_TIMEOUT_EN (forced termination after
// TIMEOUT_PAIRS wait pairs, reported through ERR).
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_PAIRS = 16
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  input  logic [1:0]  REQ_BE,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        CLK_68KCLK,
  output logic [22:0] M68K_ADDR,
  output logic        M68K_RW,
  output logic        nAS,
  output logic        nUDS,
  output logic        nLDS,
  output logic [15:0] M68K_DOUT,
  output logic        M68K_DOE,
  input  logic [15:0] M68K_DIN,
  input  logic        nDTACK
);

  // The wait-pair counter is five bits wide; reject limits it cannot reach
  if ((TIMEOUT_PAIRS < 1) || (TIMEOUT_PAIRS > 31)) begin : gBadTimeout
    $error("m68k_bus_master: TIMEOUT_PAIRS must be in 1..31");
  end

  busState_e   state;
  logic        accept;
  logic        reqRw;
  logic [22:0] reqAddr;
  logic [15:0] reqWdata;
  logic [1:0]  reqBe;

  // A request is only taken in the low half of the 68k clock so S0 lands high
  assign accept = (state == ST_IDLE) && REQ && !CLK_68KCLK;

`ifdef BUS_TIMEOUT_EN
  logic waitExpired;
  logic pairStart;
  logic timerClear;
  logic timedOut;

  assign timerClear = (state == ST_S0);
  assign pairStart  = ((state == ST_S4) || (state == ST_W2)) && nDTACK && !waitExpired;

  m68k_wait_timer #(
    .TIMEOUT_PAIRS(TIMEOUT_PAIRS)
  ) uWaitTimer (
    .clk      (CLK_24M),
    .rstN     (nRESET),
    .clear    (timerClear),
    .pairStart(pairStart),
    .expired  (waitExpired)
  );
`else
  assign ERR = 1'b0;
`endif

  // Free-running 68k clock: CLK_24M divided by two
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      CLK_68KCLK <= 1'b0;
    end else begin
      CLK_68KCLK <= ~CLK_68KCLK;
    end
  end

  // Hold the request fields for the whole cycle once accepted
  always_ff @(posedge CLK_24M) begin
    if (accept) begin
      reqRw    <= REQ_RW;
      reqAddr  <= REQ_ADDR;
      reqWdata <= REQ_WDATA;
      reqBe    <= REQ_BE;
    end
  end

  // Bus-cycle sequencer; every bus pin is set on entry to the state it belongs to
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      nAS       <= 1'b1;
      nUDS      <= 1'b1;
      nLDS      <= 1'b1;
      M68K_RW   <= 1'b1;
      M68K_DOE  <= 1'b0;
      M68K_ADDR <= '0;
      M68K_DOUT <= '0;
      ACK       <= 1'b0;
      BUSY      <= 1'b0;
      RDATA     <= '0;
`ifdef BUS_TIMEOUT_EN
      ERR       <= 1'b0;
      timedOut  <= 1'b0;
`endif
    end else begin
      ACK <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      ERR <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_S0;
            BUSY     <= 1'b1;
            M68K_RW  <= REQ_RW;
            M68K_DOE <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            timedOut <= 1'b0;
`endif
          end
        end
        ST_S0: begin
          state     <= ST_S1;
          M68K_ADDR <= reqAddr;
        end
        ST_S1: begin
          state <= ST_S2;
          nAS   <= 1'b0;
          // Reads assert data strobes together with nAS
          if (reqRw) begin
            nUDS <= ~reqBe[BE_UPPER];
            nLDS <= ~reqBe[BE_LOWER];
          end
        end
        ST_S2: begin
          state <= ST_S3;
          if (!reqRw) begin
            M68K_DOUT <= reqWdata;
            M68K_DOE  <= 1'b1;
          end
        end
        ST_S3: begin
          state <= ST_S4;
          // Writes assert data strobes one state after the data is driven
          if (!reqRw) begin
            nUDS <= ~reqBe[BE_UPPER];
            nLDS <= ~reqBe[BE_LOWER];
          end
        end
        ST_S4, ST_W2: begin
          // nDTACK sample point; a wait pair keeps the 68k clock phase intact
          if (!nDTACK) begin
            state <= ST_S5;
`ifdef BUS_TIMEOUT_EN
          end else if (waitExpired) begin
            state    <= ST_S5;
            timedOut <= 1'b1;
`endif
          end else begin
            state <= ST_W1;
          end
        end
        ST_W1: begin
          state <= ST_W2;
        end
        ST_S5: begin
          state <= ST_S6;
        end
        ST_S6: begin
          state <= ST_S7;
          nAS   <= 1'b1;
          nUDS  <= 1'b1;
          nLDS  <= 1'b1;
          ACK   <= 1'b1;
          if (reqRw) begin
`ifdef BUS_TIMEOUT_EN
            RDATA <= timedOut ? RDATA_TIMEOUT : M68K_DIN;
`else
            RDATA <= M68K_DIN;
`endif
          end
`ifdef BUS_TIMEOUT_EN
          ERR <= timedOut;
`endif
        end
        ST_S7: begin
          state    <= ST_IDLE;
          BUSY     <= 1'b0;
          M68K_RW  <= 1'b1;
          M68K_DOE <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Scoreboard bench for m68k_bus_master: each request pushes its expected
// completion; a bus monitor pops it at ACK and checks data, latency, strobe
// widths and bus stability. An nDTACK responder inserts the requested waits.
`timescale 1ns/1ps
module tb_m68k_bus_master;

  localparam int TO_PAIRS = 4;

  logic        CLK_24M   = 1'b0;
  logic        nRESET    = 1'b1;
  logic        REQ       = 1'b0;
  logic        REQ_RW    = 1'b1;
  logic [22:0] REQ_ADDR  = '0;
  logic [15:0] REQ_WDATA = '0;
  logic [1:0]  REQ_BE    = 2'b11;
  logic [15:0] M68K_DIN  = '0;
  logic        nDTACK    = 1'b1;
  logic        ACK, ERR, BUSY, CLK_68KCLK, M68K_RW, nAS, nUDS, nLDS, M68K_DOE;
  logic [15:0] RDATA, M68K_DOUT;
  logic [22:0] M68K_ADDR;

  always #5 CLK_24M = ~CLK_24M;

  m68k_bus_master #(.TIMEOUT_PAIRS(TO_PAIRS)) dut (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .REQ(REQ), .REQ_RW(REQ_RW),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE),
    .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY), .CLK_68KCLK(CLK_68KCLK),
    .M68K_ADDR(M68K_ADDR), .M68K_RW(M68K_RW), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
    .M68K_DOUT(M68K_DOUT), .M68K_DOE(M68K_DOE), .M68K_DIN(M68K_DIN), .nDTACK(nDTACK)
  );

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          waits;
    logic [15:0] rdata;
    logic        err;
  } expTxn_t;

  expTxn_t expQ[$];
  int      nChecks = 0;
  int      nFails  = 0;
  logic [15:0] lastRd = '0;
  int      dtWaits = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request (call just after a falling edge) and queue its expected completion
  task automatic pushReq(input logic rw, input logic [22:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, input int waits, input logic [15:0] din);
    expTxn_t e;
    e.rw = rw; e.addr = addr; e.wdata = wdata; e.be = be;
    e.waits = waits; e.err = 1'b0;
`ifdef BUS_TIMEOUT_EN
    if (waits > TO_PAIRS) begin
      e.waits = TO_PAIRS;
      e.err   = 1'b1;
    end
`endif
    if (rw) e.rdata = e.err ? 16'hFFFF : din;
    else    e.rdata = lastRd;
    lastRd = e.rdata;
    expQ.push_back(e);
    dtWaits   = waits;
    M68K_DIN  = din;
    REQ_RW    = rw;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    REQ_BE    = be;
    REQ       = 1'b1;
  endtask

  // nDTACK responder: assert once nAS has been low long enough for the wanted wait pairs
  int asCnt = 0;
  always @(negedge CLK_24M) begin
    if (nAS === 1'b0) asCnt++;
    else asCnt = 0;
    nDTACK = (nAS === 1'b0 && asCnt >= 3 + 2 * dtWaits) ? 1'b0 : 1'b1;
  end

  // Bus monitor and scoreboard
  int      off = 0, asLow = 0, udsLow = 0, ldsLow = 0, doeHi = 0;
  int      rwBad = 0, addrBad = 0, idleBad = 0, ackCount = 0;
  bit      inCyc = 1'b0;
  logic    prevBusy = 1'b0;
  expTxn_t cur;
  always @(negedge CLK_24M) begin
    if (!nRESET) begin
      inCyc    = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (BUSY && !prevBusy) begin
        checkVal("s0_phase", CLK_68KCLK, 1);
        checkVal("s0_queued", expQ.size(), 1);
        if (expQ.size() > 0) cur = expQ[0];
        inCyc = 1'b1;
        off = 0; asLow = 0; udsLow = 0; ldsLow = 0; doeHi = 0; rwBad = 0; addrBad = 0;
      end else if (inCyc) begin
        off++;
      end
      if (inCyc) begin
        if (M68K_RW !== cur.rw) rwBad++;
        if (off >= 1 && M68K_ADDR !== cur.addr) addrBad++;
        if (nAS === 1'b0) asLow++;
        if (nUDS === 1'b0) udsLow++;
        if (nLDS === 1'b0) ldsLow++;
        if (M68K_DOE === 1'b1) doeHi++;
        if (ACK === 1'b1) begin
          ackCount++;
          checkVal("ack_latency", off, 7 + 2 * cur.waits);
          checkVal("rdata", RDATA, cur.rdata);
          checkVal("err", ERR, cur.err);
          checkVal("nas_low_cycles", asLow, 5 + 2 * cur.waits);
          checkVal("nuds_low_cycles", udsLow, cur.be[1] ? ((cur.rw ? 5 : 3) + 2 * cur.waits) : 0);
          checkVal("nlds_low_cycles", ldsLow, cur.be[0] ? ((cur.rw ? 5 : 3) + 2 * cur.waits) : 0);
          checkVal("doe_cycles", doeHi, cur.rw ? 0 : 5 + 2 * cur.waits);
          checkVal("rw_stable", rwBad, 0);
          checkVal("addr_stable", addrBad, 0);
          if (!cur.rw) checkVal("dout", M68K_DOUT, cur.wdata);
          if (expQ.size() > 0) void'(expQ.pop_front());
          inCyc = 1'b0;
        end
      end else begin
        if (ACK !== 1'b0) checkVal("ack_outside_cycle", ACK, 0);
        if (!BUSY && (M68K_RW !== 1'b1 || M68K_DOE !== 1'b0 || nAS !== 1'b1 ||
                      nUDS !== 1'b1 || nLDS !== 1'b1)) idleBad++;
      end
      prevBusy = BUSY;
    end
  end

  task automatic waitAck(input int maxCyc);
    int  start;
    bit  got;
    start = ackCount;
    got   = 1'b0;
    for (int i = 0; i < maxCyc && !got; i++) begin
      @(negedge CLK_24M); #1;
      if (ackCount != start) got = 1'b1;
    end
    checkVal("ack_seen", ackCount - start, 1);
  endtask

  // Wait (bounded) for an idle falling edge with the given 68k clock level
  task automatic waitPhase(input logic ph);
    int n;
    n = 0;
    do begin
      @(negedge CLK_24M); #1;
      n++;
    end while ((CLK_68KCLK !== ph || BUSY !== 1'b0) && n < 20);
    checkVal("phase_found", (CLK_68KCLK === ph && BUSY === 1'b0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", nChecks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #2 nRESET = 1'b0;
    #20;
    checkVal("rst_ack", ACK, 0);
    checkVal("rst_err", ERR, 0);
    checkVal("rst_busy", BUSY, 0);
    checkVal("rst_rdata", RDATA, 0);
    checkVal("rst_clk68", CLK_68KCLK, 0);
    checkVal("rst_strobes", {nAS, nUDS, nLDS}, 3'b111);
    checkVal("rst_rw_doe", {M68K_RW, M68K_DOE}, 2'b10);
    checkVal("rst_addr", M68K_ADDR, 0);
    checkVal("rst_dout", M68K_DOUT, 0);
    @(negedge CLK_24M) nRESET = 1'b1;
    repeat (3) @(negedge CLK_24M);

    // Zero-wait read, immediate start
    waitPhase(1'b0);
    pushReq(1'b1, 23'h000100, 16'h0000, 2'b11, 0, 16'h1234);
    @(posedge CLK_24M); #1;
    checkVal("start_immediate", BUSY, 1);
    waitAck(40);
    REQ = 1'b0;

    // Zero-wait lower-byte write
    waitPhase(1'b0);
    pushReq(1'b0, 23'h200000, 16'hBEEF, 2'b01, 0, 16'h0000);
    waitAck(40);
    REQ = 1'b0;

    // Two wait pairs on an upper-byte read
    waitPhase(1'b0);
    pushReq(1'b1, 23'h7FFFFF, 16'h0000, 2'b10, 2, 16'hA5C3);
    waitAck(60);
    REQ = 1'b0;

    // Request raised in the high phase starts one cycle later
    waitPhase(1'b1);
    pushReq(1'b1, 23'h012345, 16'h0000, 2'b11, 0, 16'h5A5A);
    @(posedge CLK_24M); #1;
    checkVal("start_delayed_wait", BUSY, 0);
    @(posedge CLK_24M); #1;
    checkVal("start_delayed_go", BUSY, 1);
    waitAck(40);
    REQ = 1'b0;

    // Back-to-back: REQ held over ACK, second request follows after a 2-cycle gap
    waitPhase(1'b0);
    pushReq(1'b0, 23'h000003, 16'h1357, 2'b11, 1, 16'h0000);
    waitAck(60);
    pushReq(1'b1, 23'h000055, 16'h0000, 2'b11, 0, 16'h0F0F);
    n = 0;
    do begin
      @(negedge CLK_24M); #1;
      n++;
    end while (BUSY !== 1'b1 && n < 10);
    checkVal("b2b_gap", n, 3);
    waitAck(40);
    REQ = 1'b0;

`ifdef BUS_TIMEOUT_EN
    // nDTACK never arrives: forced termination after TO_PAIRS wait pairs
    waitPhase(1'b0);
    pushReq(1'b1, 23'h0000AA, 16'h0000, 2'b11, 1000, 16'h1111);
    waitAck(100);
    REQ = 1'b0;
`endif

    // Reset in the middle of a wait state
    waitPhase(1'b0);
    pushReq(1'b1, 23'h000777, 16'h0000, 2'b11, 1000, 16'h2222);
    n = 0;
    do begin
      @(negedge CLK_24M); #1;
      n++;
    end while (!(inCyc && off == 5) && n < 30);
    checkVal("reached_w1", off, 5);
    nRESET = 1'b0;
    REQ    = 1'b0;
    #1;
    checkVal("rstw_strobes", {nAS, nUDS, nLDS}, 3'b111);
    checkVal("rstw_doe", M68K_DOE, 0);
    checkVal("rstw_busy_ack", {BUSY, ACK}, 2'b00);
    checkVal("rstw_rdata", RDATA, 0);
    expQ.delete();
    lastRd  = '0;
    dtWaits = 0;
    repeat (2) @(negedge CLK_24M);
    #1 nRESET = 1'b1;
    repeat (4) @(negedge CLK_24M);

    // Clean cycle after the interrupted one
    waitPhase(1'b0);
    pushReq(1'b1, 23'h00ABCD, 16'h0000, 2'b11, 0, 16'hCAFE);
    waitAck(40);
    REQ = 1'b0;
    repeat (4) @(negedge CLK_24M);

    checkVal("idle_bus", idleBad, 0);
    checkVal("queue_empty", expQ.size(), 0);
    checkVal("ack_total", ackCount,
`ifdef BUS_TIMEOUT_EN
             8
`else
             7
`endif
    );
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
